// File: rtl/if_prefetch_queue_if.sv
// Fetch-queue bus bundle: redirect input, instruction-memory request/response,
// and the dequeue side facing the IF/ID register.
//   master : the prefetch queue (drives requests and dequeue outputs)
//   slave  : the environment (memory, ID-stage redirect, IF/ID consumer)
interface if_prefetch_queue_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  imem_req_valid;
    logic [DATA_WIDTH-1:0] imem_req_addr;
    logic                  imem_req_ready;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  deq_ready;
    logic                  deq_valid;
    logic [DATA_WIDTH-1:0] deq_pc;
    logic [DATA_WIDTH-1:0] deq_inst;
    logic [CW-1:0]         count;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, deq_ready,
        output imem_req_valid, imem_req_addr, deq_valid, deq_pc, deq_inst, count
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, deq_ready,
        input  imem_req_valid, imem_req_addr, deq_valid, deq_pc, deq_inst, count
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue ahead of the IF/ID register.
// Issues in-order pipelined reads, buffers returned words with their PCs in a
// DEPTH-entry FIFO and presents one {pc, inst} per cycle. A redirect flushes the
// FIFO and discards responses still in flight for the old path.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : if_prefetch_queue_if.master (redirect, imem req/rsp, dequeue, count)
module if_prefetch_queue #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic clk,
    input  logic rst,
    if_prefetch_queue_if.master bus
);
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          fetch_en;

    logic [DW-1:0] fetch_pc;
    logic [DW-1:0] rsp_pc;
    logic [CW-1:0] count_q;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_cnt_next;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [DW-1:0] pc_mem   [DEPTH];
    logic [DW-1:0] inst_mem [DEPTH];

    logic          redirect;
    logic          credit;
    logic          req_valid_c;
    logic          accept;
    logic          rsp_take;
    logic          drop;
    logic          enq;
    logic          deq_valid_c;
    logic          pop;

    // Handshake qualifiers
    assign redirect    = bus.redirect_valid;
    // Credit covers both buffered entries and in-flight reads, so an enqueue
    // can never find the FIFO full.
    assign credit      = (SW'(outstanding) + SW'(count_q)) < SW'(DEPTH);
    assign req_valid_c = !rst && fetch_en && !redirect && credit;
    assign accept      = req_valid_c && bus.imem_req_ready;
    // Responses with nothing outstanding are stale (e.g. across reset).
    assign rsp_take    = bus.imem_rsp_valid && (outstanding != '0);
    assign drop        = rsp_take && (drop_cnt != '0);
    assign enq         = rsp_take && (drop_cnt == '0) && !redirect;
    assign deq_valid_c = !rst && (count_q != '0) && !redirect;
    assign pop         = deq_valid_c && bus.deq_ready;

    // A same-cycle response belongs to the old path and is consumed here.
    assign drop_cnt_next = redirect ? (outstanding - CW'(rsp_take))
                                    : (drop_cnt - CW'(drop));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_BOOT:  state_next = S_FETCH;
            S_FETCH: if (redirect && (drop_cnt_next != '0)) state_next = S_DRAIN;
            S_DRAIN: if (drop_cnt_next == '0) state_next = S_FETCH;
            default: state_next = S_BOOT;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        fetch_en = 1'b0;
        unique case (state)
            S_FETCH, S_DRAIN: fetch_en = 1'b1;
            default:          fetch_en = 1'b0;
        endcase
    end

    // Fetch/response PCs, counters and FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count_q     <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            drop_cnt <= drop_cnt_next;

            unique case ({accept, rsp_take})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            if (redirect) begin
                fetch_pc <= bus.redirect_pc;
                rsp_pc   <= bus.redirect_pc;
                count_q  <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + DW'(4);
                if (enq) begin
                    rsp_pc <= rsp_pc + DW'(4);
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                unique case ({enq, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            inst_mem[wr_ptr] <= bus.imem_rsp_data;
        end
    end

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.deq_valid      = deq_valid_c;
    assign bus.deq_pc         = pc_mem[rd_ptr];
    assign bus.deq_inst       = inst_mem[rd_ptr];
    assign bus.count          = count_q;
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: in-order memory model with settable
// latency and ready, dequeue log, and hand-derived expected sequences.
module tb_if_prefetch_queue;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_prefetch_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    if_prefetch_queue #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .RESET_PC  (32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc;
    int lat;
    bit rsp_en;
    int first_req;

    logic [31:0] q_addr [$];
    int          q_due  [$];
    logic [31:0] req_log  [$];
    logic [31:0] pc_log   [$];
    logic [31:0] inst_log [$];

    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_deq_valid;
    logic [2:0]  s_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input logic [31:0] q [$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_0BAD;
    endfunction

    // One clock: sample mid-cycle, then advance the memory model after the edge.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        acc         = bus.imem_req_valid & bus.imem_req_ready;
        a           = bus.imem_req_addr;
        s_req_valid = bus.imem_req_valid;
        s_req_addr  = a;
        s_deq_valid = bus.deq_valid;
        s_count     = bus.count;
        if (acc) begin
            req_log.push_back(a);
            if (first_req < 0) first_req = cyc;
        end
        if (bus.deq_valid & bus.deq_ready) begin
            pc_log.push_back(bus.deq_pc);
            inst_log.push_back(bus.deq_inst);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rsp_en && bus.imem_rsp_valid && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (acc) begin
            q_addr.push_back(a);
            q_due.push_back(cyc - 1 + lat);
        end
        if (rsp_en) begin
            if (q_addr.size() > 0 && q_due[0] <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = ~q_addr[0];
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end
        end
    endtask

    // One reset cycle (cycle 0); leaves rst low at the start of cycle 1.
    task automatic reset_dut(input int l);
        q_addr.delete();
        q_due.delete();
        req_log.delete();
        pc_log.delete();
        inst_log.delete();
        lat       = l;
        rsp_en    = 1'b1;
        first_req = -1;
        cyc       = 0;
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.deq_ready      = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Streaming with 1-cycle memory
        reset_dut(1);
        check("rst_req_valid", 32'(s_req_valid), 32'd0);
        check("rst_deq_valid", 32'(s_deq_valid), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        tick();
        check("boot_req_valid", 32'(s_req_valid), 32'd0);
        repeat (11) tick();
        check("first_req_cyc", 32'(first_req), 32'd2);
        check("first_req_addr", q_at(req_log, 0), 32'h0);
        check("stream_pops", 32'(pc_log.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check("stream_pc", q_at(pc_log, i), 32'(4 * i));
            check("stream_inst", q_at(inst_log, i), ~32'(4 * i));
        end

        // Back-pressure fills the queue, then drains in order
        reset_dut(1);
        bus.deq_ready = 1'b0;
        repeat (10) tick();
        check("bp_req_cnt", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("bp_req_addr", q_at(req_log, i), 32'(4 * i));
        check("bp_req_valid", 32'(s_req_valid), 32'd0);
        check("bp_count", 32'(s_count), 32'd4);
        bus.deq_ready = 1'b1;
        repeat (10) tick();
        for (int i = 0; i < 5; i++) check("bp_pop_pc", q_at(pc_log, i), 32'(4 * i));
        check("bp_resume_addr", q_at(req_log, 4), 32'h10);

        // Redirect with two reads in flight, latency 3
        reset_dut(3);
        repeat (3) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        check("rd_req_blocked", 32'(s_req_valid), 32'd0);
        check("rd_state_drain", 32'(dut.state), 32'd2);
        tick();
        check("rd_state_drain2", 32'(dut.state), 32'd2);
        tick();
        check("rd_state_fetch", 32'(dut.state), 32'd1);
        repeat (10) tick();
        check("rd_req_target", q_at(req_log, 2), 32'h100);
        check("rd_first_pc", q_at(pc_log, 0), 32'h100);
        check("rd_first_inst", q_at(inst_log, 0), ~32'h100);
        check("rd_second_pc", q_at(pc_log, 1), 32'h104);

        // Redirect colliding with response and dequeue (outstanding=3, count=1)
        reset_dut(3);
        bus.deq_ready = 1'b0;
        repeat (5) tick();
        check("col_pre_count", 32'(bus.count), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        bus.deq_ready      = 1'b1;
        tick();
        check("col_req_valid", 32'(s_req_valid), 32'd0);
        check("col_deq_valid", 32'(s_deq_valid), 32'd0);
        check("col_count", 32'(bus.count), 32'd0);
        check("col_drop_cnt", 32'(dut.drop_cnt), 32'd2);
        bus.redirect_valid = 1'b0;
        repeat (12) tick();
        check("col_first_pc", q_at(pc_log, 0), 32'h200);
        check("col_first_inst", q_at(inst_log, 0), ~32'h200);
        check("col_second_pc", q_at(pc_log, 1), 32'h204);

        // Memory stall: address held, advances by 4 after accept
        reset_dut(1);
        tick();
        bus.imem_req_ready = 1'b0;
        repeat (5) begin
            tick();
            check("stall_valid", 32'(s_req_valid), 32'd1);
            check("stall_addr", s_req_addr, 32'h0);
        end
        bus.imem_req_ready = 1'b1;
        tick();
        check("stall_accept", 32'(req_log.size()), 32'd1);
        tick();
        check("stall_next_addr", s_req_addr, 32'h4);

        // Reset mid-flight, late responses ignored
        reset_dut(3);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_req_valid", 32'(s_req_valid), 32'd0);
        check("mrst_deq_valid", 32'(s_deq_valid), 32'd0);
        check("mrst_count", 32'(bus.count), 32'd0);
        q_addr.delete();
        q_due.delete();
        req_log.delete();
        pc_log.delete();
        inst_log.delete();
        rsp_en             = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        check("mrst_boot_req", 32'(s_req_valid), 32'd0);
        check("mrst_boot_deq", 32'(s_deq_valid), 32'd0);
        tick();
        check("mrst_req_valid2", 32'(s_req_valid), 32'd1);
        check("mrst_req_addr", s_req_addr, 32'h0);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        rsp_en             = 1'b1;
        repeat (8) tick();
        check("mrst_first_pc", q_at(pc_log, 0), 32'h0);
        check("mrst_first_inst", q_at(inst_log, 0), ~32'h0);
        check("mrst_second_pc", q_at(pc_log, 1), 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
